avalon_test_master: RTL
=======================

Name: avalon_test_master

Overview:
- Avalon-MM initiator that runs one complete arithmetic test on the testbench wrapper's slave register file.
- Sequence: reset the test harness, enable the randomisers, wait a programmed number of cycles, freeze the scoreboard, then read back the data counter, event counter and rand_a snapshot.
- Sits in the clk domain on the host side, in place of a soft CPU, for standalone or regression runs.

Parameters:
WIDTH, 32, Avalon data width and result register width
CNT_WIDTH, 32, width of the run-length counter
RESET_HOLD, 4, clk cycles the harness reset bit is held before enable (≥1)
READ_LATENCY, 1, fixed clk cycles from read strobe to valid readdata (≥1)

Ports:
clk  in  1  system clock, same clock as the slave's clk
reset  in  1  synchronous, active-high
i_start  in  1  one-cycle start pulse; ignored while o_busy=1
i_abort  in  1  abort request; honoured only while o_busy=1
i_run_cycles  in  CNT_WIDTH  enabled-run length in clk cycles; sampled when start is accepted
o_busy  out  1  high from the cycle after start is accepted until return to IDLE
o_done  out  1  one-cycle pulse when a run completes normally
o_data_ctr  out  WIDTH  captured O1 (address 0x2)
o_event_ctr  out  WIDTH  captured O2 (address 0x3)
o_rand_a  out  WIDTH  captured O3 (address 0x4)
o_fail  out  1  registered result: 1 when the captured event_ctr is non-zero
master_address  out  4  word address
master_read  out  1  read strobe
master_write  out  1  write strobe
master_writedata  out  WIDTH  write data
master_readdata  in  WIDTH  read data, valid READ_LATENCY cycles after master_read

Behaviour:
- Reset values:
  - All outputs are 0; state is IDLE.
  - master_read and master_write are 0 in the cycle after reset is asserted, including when reset arrives mid-operation.
  - Result registers are cleared.
- Bus rules:
  - Every access lasts exactly one cycle; there is no waitrequest.
  - master_read and master_write are never high together.
  - master_address and master_writedata are held at 0 when idle.
- Control word written to address 0x0: bit0 = harness reset, bit1 = enable, bit2 = freeze; upper bits are 0.
- States:
  - IDLE: on i_start, latch i_run_cycles → WR_RST.
  - WR_RST: write 0x1 → HOLD; load the hold counter with RESET_HOLD-1.
  - HOLD: decrement the hold counter; at 0 → WR_EN.
  - WR_EN: write 0x2 → RUN, or directly → WR_FRZ if run_cycles = 0. Load the run counter with run_cycles-1.
  - RUN: decrement the run counter; at 0 → WR_FRZ. Total enabled window between the WR_EN and WR_FRZ write cycles is exactly run_cycles clk cycles.
  - WR_FRZ: write 0x6 → RD(0x2).
  - RD(a): assert read at address a for one cycle, then wait READ_LATENCY-1 idle cycles, then capture master_readdata on the cycle that is READ_LATENCY after the strobe. Reads run in order 0x2 → 0x3 → 0x4. Reads are non-overlapping: the next strobe comes no earlier than the cycle after capture.
  - WR_STOP: write 0x4 (frozen, disabled) → DONE.
  - DONE: o_done=1 for one cycle; o_fail updated together with it → IDLE.
- Capture: o_data_ctr, o_event_ctr and o_rand_a update only at their own capture cycle. o_fail is set from o_event_ctr != 0 in the DONE cycle.
- Abort:
  - If i_abort=1 in any busy state other than DONE, the next state is WR_ABORT.
  - WR_ABORT writes 0x1 (harness held in reset) → IDLE. o_done does not pulse.
  - Result registers keep any values already captured; o_fail is unchanged.
- Simultaneous events:
  - i_start and i_abort in IDLE: start wins and abort is ignored.
  - reset has priority over everything.
- Counters: the run counter is CNT_WIDTH bits and does not wrap. i_run_cycles = 2^CNT_WIDTH-1 is legal and runs the full length.
- o_busy = 1 in every state except IDLE.

Test Plan:
- Nominal: reset, then i_start with run_cycles=10, slave model returns 0x64/0x0/0xCAFEF00D. Required:
  - Writes 0x1, 0x2, 0x6, 0x4 at address 0.
  - Enabled window of 10 cycles.
  - Reads at 0x2, 0x3, 0x4.
  - o_data_ctr=0x64, o_event_ctr=0, o_rand_a=0xCAFEF00D, o_fail=0.
  - o_done pulses once.
- Failure: same run, but O2 returns 0x3. Required: o_event_ctr=3, o_fail=1 in the o_done cycle.
- Zero length: run_cycles=0. Required: the 0x6 write occurs on the cycle after the 0x2 write, and the run completes normally.
- Latency: READ_LATENCY=3, with the slave model driving readdata 3 cycles after each strobe. Required: correct capture, and successive read strobes spaced at least 4 cycles apart.
- Abort: assert i_abort at cycle 5 of RUN (run_cycles=100). Required: the next bus cycle is a write of 0x1; then IDLE with o_done=0 and results unchanged. A subsequent i_start runs normally.
- Protocol checks:
  - Reset asserted during RD(0x3): master_read=0 and all outputs 0 on the next cycle.
  - i_start during busy is ignored.
  - No cycle ever has master_read and master_write both high.

Source files
------------

// File: rtl/avalon_test_master_if.sv
// Avalon-MM bus between the test master and the harness slave register file.
// Single-cycle accesses, no waitrequest; readdata is valid a fixed latency after the strobe.
interface avalon_test_master_if #(
    parameter int WIDTH = 32
) ();
    logic [3:0]       master_address;
    logic             master_read;
    logic             master_write;
    logic [WIDTH-1:0] master_writedata;
    logic [WIDTH-1:0] master_readdata;

    modport master (
        output master_address,
        output master_read,
        output master_write,
        output master_writedata,
        input  master_readdata
    );

    modport slave (
        input  master_address,
        input  master_read,
        input  master_write,
        input  master_writedata,
        output master_readdata
    );
endinterface

// File: rtl/avalon_test_master.sv
// Avalon-MM initiator that runs one arithmetic test on the harness: reset, enable for a
// programmed number of cycles, freeze, then read back data counter, event counter and rand_a.
module avalon_test_master #(
    parameter int WIDTH        = 32,
    parameter int CNT_WIDTH    = 32,
    parameter int RESET_HOLD   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [CNT_WIDTH-1:0] i_run_cycles,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [WIDTH-1:0]     o_data_ctr,
    output logic [WIDTH-1:0]     o_event_ctr,
    output logic [WIDTH-1:0]     o_rand_a,
    output logic                 o_fail,
    avalon_test_master_if.master avm
);
    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    // Control word bits: [0] harness reset, [1] enable, [2] freeze
    localparam logic [WIDTH-1:0] CTRL_RST  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CTRL_EN   = WIDTH'(2);
    localparam logic [WIDTH-1:0] CTRL_FRZ  = WIDTH'(6);
    localparam logic [WIDTH-1:0] CTRL_STOP = WIDTH'(4);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_RST,
        S_HOLD,
        S_WR_EN,
        S_RUN,
        S_WR_FRZ,
        S_RD,
        S_RD_WAIT,
        S_WR_STOP,
        S_DONE,
        S_WR_ABORT
    } state_t;

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_run_cycles;
    logic [CNT_WIDTH-1:0] r_run_ctr;
    logic [HOLD_W-1:0]    r_hold_ctr;
    logic [LAT_W-1:0]     r_lat_ctr;
    logic [1:0]           r_rd_idx;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_fail;
    logic [WIDTH-1:0]     r_data_ctr;
    logic [WIDTH-1:0]     r_event_ctr;
    logic [WIDTH-1:0]     r_rand_a;
    logic [3:0]           r_address;
    logic                 r_read;
    logic                 r_write;
    logic [WIDTH-1:0]     r_writedata;
    logic                 w_abort;

    // WR_ABORT already heads to IDLE, so a held abort cannot keep the FSM busy.
    assign w_abort = i_abort && (r_state != S_IDLE) && (r_state != S_DONE)
                     && (r_state != S_WR_ABORT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_run_cycles <= '0;
            r_run_ctr    <= '0;
            r_hold_ctr   <= '0;
            r_lat_ctr    <= '0;
            r_rd_idx     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_data_ctr   <= '0;
            r_event_ctr  <= '0;
            r_rand_a     <= '0;
            r_address    <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_writedata  <= '0;
        end else begin
            // Bus outputs are registered from the next state, so each access lasts one cycle
            r_address   <= '0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_writedata <= '0;
            r_done      <= 1'b0;
            if (w_abort) begin
                r_state     <= S_WR_ABORT;
                r_write     <= 1'b1;
                r_writedata <= CTRL_RST;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_run_cycles <= i_run_cycles;
                            r_busy       <= 1'b1;
                            r_state      <= S_WR_RST;
                            r_write      <= 1'b1;
                            r_writedata  <= CTRL_RST;
                        end
                    end
                    S_WR_RST: begin
                        r_hold_ctr <= HOLD_W'(RESET_HOLD - 1);
                        r_state    <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (r_hold_ctr == '0) begin
                            r_state     <= S_WR_EN;
                            r_write     <= 1'b1;
                            r_writedata <= CTRL_EN;
                        end else begin
                            r_hold_ctr <= r_hold_ctr - HOLD_W'(1);
                        end
                    end
                    S_WR_EN: begin
                        r_run_ctr <= r_run_cycles - CNT_WIDTH'(1);
                        if (r_run_cycles == '0) begin
                            r_state     <= S_WR_FRZ;
                            r_write     <= 1'b1;
                            r_writedata <= CTRL_FRZ;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (r_run_ctr == '0) begin
                            r_state     <= S_WR_FRZ;
                            r_write     <= 1'b1;
                            r_writedata <= CTRL_FRZ;
                        end else begin
                            r_run_ctr <= r_run_ctr - CNT_WIDTH'(1);
                        end
                    end
                    S_WR_FRZ: begin
                        r_rd_idx  <= 2'd0;
                        r_state   <= S_RD;
                        r_read    <= 1'b1;
                        r_address <= 4'h2;
                    end
                    S_RD: begin
                        r_lat_ctr <= LAT_W'(READ_LATENCY - 1);
                        r_state   <= S_RD_WAIT;
                    end
                    S_RD_WAIT: begin
                        if (r_lat_ctr == '0) begin
                            case (r_rd_idx)
                                2'd0:    r_data_ctr  <= avm.master_readdata;
                                2'd1:    r_event_ctr <= avm.master_readdata;
                                default: r_rand_a    <= avm.master_readdata;
                            endcase
                            if (r_rd_idx == 2'd2) begin
                                r_state     <= S_WR_STOP;
                                r_write     <= 1'b1;
                                r_writedata <= CTRL_STOP;
                            end else begin
                                r_rd_idx  <= r_rd_idx + 2'd1;
                                r_state   <= S_RD;
                                r_read    <= 1'b1;
                                r_address <= 4'h3 + {2'b00, r_rd_idx};
                            end
                        end else begin
                            r_lat_ctr <= r_lat_ctr - LAT_W'(1);
                        end
                    end
                    S_WR_STOP: begin
                        r_done  <= 1'b1;
                        r_fail  <= (r_event_ctr != '0);
                        r_state <= S_DONE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_busy               = r_busy;
    assign o_done               = r_done;
    assign o_fail               = r_fail;
    assign o_data_ctr           = r_data_ctr;
    assign o_event_ctr          = r_event_ctr;
    assign o_rand_a             = r_rand_a;
    assign avm.master_address   = r_address;
    assign avm.master_read      = r_read;
    assign avm.master_write     = r_write;
    assign avm.master_writedata = r_writedata;
endmodule
